div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Iterative unsigned restoring divider (Q = N / D, R = N % D), one quotient bit per clock.
//  Generalised-width, sequential next generation of the team's combinational divider.
//  Start/busy/done handshake; sits beside the ALU datapath as a multi-cycle functional unit.
// PARAMETERS
//  WIDTH   16   operand/result width in bits (>= 2)
// PORTS
//  clk          in   1      system clock, all state updates on rising edge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      request; sampled only when busy==0
//  N            in   WIDTH  dividend, captured on accepted start
//  D            in   WIDTH  divisor, captured on accepted start
//  busy         out  1      1 while a division is in progress
//  done         out  1      single-cycle pulse: Q/R/div_by_zero valid
//  Q            out  WIDTH  quotient, registered, held until next done
//  R            out  WIDTH  remainder, registered, held until next done
//  div_by_zero  out  1      registered flag, updated with Q/R
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, Q=0, R=0, div_by_zero=0; counter and work regs 0.
//  - States: IDLE -> CALC -> FIN -> IDLE.
//    IDLE: start=1 and D!=0 -> capture N,D; partial rem=0; cnt=WIDTH-1; go CALC; busy=1.
//          start=1 and D==0 -> go FIN directly (no CALC); result Q={WIDTH{1}}, R=N, dbz=1.
//    CALC: each cycle: rem={rem[WIDTH-2:0],N_q[cnt]}; if rem>=D_q: rem-=D_q, Q_q[cnt]=1.
//          rem held WIDTH+1 bits internally so the compare never overflows.
//          cnt==0 -> go FIN after this step; otherwise cnt-=1.
//    FIN:  load Q/R/div_by_zero outputs, done=1 for this cycle only, busy=0 -> IDLE.
//  - Latency: start sampled at edge k -> done=1 in the cycle after edge k+WIDTH+1 (D!=0);
//    after edge k+1 for D==0.
//  - start while busy=1: ignored, no queuing; captured operands unchanged.
//  - start in FIN cycle: ignored (busy is 0 but state is not IDLE); accepted from next cycle.
//  - N/D may change freely after the accepting edge; result uses captured values.
//  - Q/R/div_by_zero change only at entry to FIN; hold between operations.
//  - rst mid-operation: aborts immediately, all outputs to reset values, no done pulse.
//  - N=0: Q=0, R=0, full latency. N<D: Q=0, R=N. D=1: Q=N, R=0.
// CONFIGURATION
//  DIV_SIGNED_EN defined: N, D, Q, R are two's complement. Magnitudes divided as above;
//   at FIN: Q negated if sign(N)!=sign(D), R takes sign of N (truncating division).
//   Overflow -2^(WIDTH-1)/-1 -> Q=-2^(WIDTH-1) (wraps), R=0, dbz=0.
//   D==0 -> Q={WIDTH{1}}, R=N, dbz=1. Latency unchanged (sign fix done in FIN load).
//  DIV_SIGNED_EN undefined: pure unsigned; no sign logic synthesised.
// STRUCTURE
//  div_pkg: state encodings (ST_IDLE, ST_CALC, ST_FIN) as localparams; counter width
//   CNT_W = $clog2(WIDTH) as a constant function/macro.
//  Sub-module div_step: combinational one-iteration restoring step
//   (rem_in, bit_in, D -> rem_out, q_bit); parametrised by WIDTH; instantiated once.
// TESTING (WIDTH=16 unless stated)
//  1. N=100, D=7, start 1 cycle -> Q=14, R=2, dbz=0, done exactly 17 cycles after start edge.
//  2. N=0xFFFF, D=1 -> Q=0xFFFF, R=0; then N=3, D=0xFFFF -> Q=0, R=3.
//  3. N=5, D=0 -> Q=0xFFFF, R=5, dbz=1, done one cycle after start; next op clears dbz.
//  4. Start N=100,D=7; pulse start N=9,D=3 at cycle 5 -> ignored, result Q=14, R=2.
//  5. rst at cycle 8 of a division -> busy=0, Q=R=0, no done; new start completes correctly.
//  6. DIV_SIGNED_EN: N=-7 (0xFFF9), D=2 -> Q=0xFFFD, R=0xFFFF; N=0x8000, D=0xFFFF -> Q=0x8000, R=0.
//  Plus random unsigned sweep with WIDTH=8 exhaustive against N/D, N%D reference model.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the sequential divider: FSM state codes and counter sizing.
package div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // Bit-counter width; operands are always at least 2 bits wide.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // One extra bit so the shifted remainder never overflows before the compare.
    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {1'b0, d});
        rem_out = q_bit ? WIDTH'(shifted - {1'b0, d}) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_seq.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module div_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] D,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);
    import div_pkg::*;

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic             dbz_q;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] n_mag;
    logic [WIDTH-1:0] d_mag;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;
`ifdef DIV_SIGNED_EN
    logic             n_neg;
    logic             d_neg;
    logic [WIDTH-1:0] r_mag;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .bit_in  (n_q[cnt]),
        .d       (d_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign busy = (state == ST_CALC);

`ifdef DIV_SIGNED_EN
    // The core divides magnitudes; signs are reapplied when the result is loaded.
    always_comb begin
        n_mag = N[WIDTH-1] ? WIDTH'(-N) : N;
        d_mag = D[WIDTH-1] ? WIDTH'(-D) : D;
        r_mag = dbz_q ? n_q : rem;
        r_res = n_neg ? WIDTH'(-r_mag) : r_mag;
        if (dbz_q)
            q_res = '1;
        else
            q_res = (n_neg ^ d_neg) ? WIDTH'(-quo) : quo;
    end
`else
    always_comb begin
        n_mag = N;
        d_mag = D;
        q_res = dbz_q ? '1 : quo;
        r_res = dbz_q ? n_q : rem;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            done        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            n_q         <= '0;
            d_q         <= '0;
            rem         <= '0;
            quo         <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            n_neg       <= 1'b0;
            d_neg       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_q <= n_mag;
                        d_q <= d_mag;
                        rem <= '0;
                        quo <= '0;
                        cnt <= CNT_W'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
                        n_neg <= N[WIDTH-1];
                        d_neg <= D[WIDTH-1];
`endif
                        dbz_q <= (D == '0);
                        state <= (D == '0) ? ST_FIN : ST_CALC;
                    end
                end
                ST_CALC: begin
                    rem      <= step_rem;
                    quo[cnt] <= step_q;
                    if (cnt == '0)
                        state <= ST_FIN;
                    else
                        cnt <= cnt - 1'b1;
                end
                ST_FIN: begin
                    Q           <= q_res;
                    R           <= r_res;
                    div_by_zero <= dbz_q;
                    done        <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed checks of div_seq at WIDTH=16 plus a sampled sweep of a WIDTH=8 instance.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] n = '0;
    logic [15:0] d = '0;
    logic        busy, done, dbz;
    logic [15:0] q, r;

    logic        start8 = 1'b0;
    logic [7:0]  n8 = '0;
    logic [7:0]  d8 = '0;
    logic        busy8, done8, dbz8;
    logic [7:0]  q8, r8;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .N(n), .D(d),
        .busy(busy), .done(done), .Q(q), .R(r), .div_by_zero(dbz)
    );

    div_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .N(n8), .D(d8),
        .busy(busy8), .done(done8), .Q(q8), .R(r8), .div_by_zero(dbz8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch on the next edge, return 1ns after the accepting edge.
    task automatic start16(input logic [15:0] nv, input logic [15:0] dv);
        @(negedge clk);
        n = nv; d = dv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait16(output int cyc);
        cyc = 41;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic op16(input string tag, input logic [15:0] nv, input logic [15:0] dv,
                        input logic [15:0] eq, input logic [15:0] er, input logic edbz);
        int cyc;
        start16(nv, dv);
        check({tag, " busy"}, 32'(busy), (dv != 0) ? 32'd1 : 32'd0);
        wait16(cyc);
        check({tag, " latency"}, cyc, (dv != 0) ? 32'd17 : 32'd1);
        check({tag, " Q"}, 32'(q), 32'(eq));
        check({tag, " R"}, 32'(r), 32'(er));
        check({tag, " dbz"}, 32'(dbz), 32'(edbz));
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " Q held"}, 32'(q), 32'(eq));
    endtask

    task automatic op8(input logic [7:0] nv, input logic [7:0] dv);
        logic [7:0] eq, er;
        int cyc, sn, sd;
        if (dv == 0) begin
            eq = 8'hFF; er = nv;
        end else begin
`ifdef DIV_SIGNED_EN
            sn = int'($signed(nv));
            sd = int'($signed(dv));
            if (nv == 8'h80 && dv == 8'hFF) begin
                eq = 8'h80; er = 8'h00;
            end else begin
                eq = 8'(sn / sd);
                er = 8'(sn % sd);
            end
`else
            sn = 0; sd = 0;
            eq = nv / dv;
            er = nv % dv;
`endif
        end
        @(negedge clk);
        n8 = nv; d8 = dv; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        n8 = ~nv;
        cyc = 41;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done8) begin
                cyc = c;
                break;
            end
        end
        check("w8 latency", cyc, (dv != 0) ? 32'd9 : 32'd1);
        check("w8 Q", 32'(q8), 32'(eq));
        check("w8 R", 32'(r8), 32'(er));
        check("w8 dbz", 32'(dbz8), (dv == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int cyc;
        int seen;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset Q", 32'(q), 32'd0);
        check("reset R", 32'(r), 32'd0);
        check("reset dbz", 32'(dbz), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        op16("100/7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
`ifdef DIV_SIGNED_EN
        op16("-7/2", 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0);
        op16("min/-1", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
        op16("-100/-7", 16'hFF9C, 16'hFFF9, 16'd14, 16'hFFFE, 1'b0);
`else
        op16("ffff/1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
        op16("3/ffff", 16'd3, 16'hFFFF, 16'd0, 16'd3, 1'b0);
        op16("ffff/ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
`endif
        op16("5/0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
        op16("10/3", 16'd10, 16'd3, 16'd3, 16'd1, 1'b0);
        op16("0/9", 16'd0, 16'd9, 16'd0, 16'd0, 1'b0);
        op16("5/9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0);
        op16("1234/1", 16'd1234, 16'd1, 16'd1234, 16'd0, 1'b0);

        // Second start while busy must not disturb the running division.
        start16(16'd100, 16'd7);
        repeat (4) @(negedge clk);
        n = 16'd9; d = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n = 16'd0; d = 16'd0;
        wait16(cyc);
        check("ignored start done seen", (cyc <= 40) ? 32'd1 : 32'd0, 32'd1);
        check("ignored start Q", 32'(q), 32'd14);
        check("ignored start R", 32'(r), 32'd2);

        // Start raised during the FIN cycle is dropped; nothing follows it.
        start16(16'd50, 16'd0);
        n = 16'd77; d = 16'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("fin start done", 32'(done), 32'd1);
        check("fin start R", 32'(r), 32'd50);
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("fin start dropped", seen, 0);

        // Abort mid-operation.
        start16(16'd100, 16'd7);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort Q", 32'(q), 32'd0);
        check("abort R", 32'(r), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("abort no done", seen, 0);
        op16("1000/33", 16'd1000, 16'd33, 16'd30, 16'd10, 1'b0);

        op8(8'd255, 8'd1);
        op8(8'd255, 8'd255);
        op8(8'd0, 8'd1);
        op8(8'd128, 8'd255);
        op8(8'd127, 8'd0);
        op8(8'd200, 8'd13);
        for (int i = 0; i < 600; i++)
            op8(8'($urandom_range(0, 255)), (i % 37 == 0) ? 8'd0 : 8'($urandom_range(1, 255)));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
